// File: rtl/stream_verify_checker_pkg.sv
// rtl/stream_verify_checker_pkg.sv - shared types, defaults and sizing helper for the stream checker
package Package_wimax;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_CHECK = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } chk_state_t;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FRAME_LEN  = 192;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_ERR_TOL    = 0;

  // Counter width able to hold 0..frame_len inclusive.
  function automatic int cnt_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/stream_verify_checker_if.sv
// rtl/stream_verify_checker_if.sv - expected/actual stream bundle for all check channels
interface stream_verify_checker_if
  import Package_wimax::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int DATA_W = DEF_DATA_W
);

  logic [N_CH-1:0]             exp_valid;
  logic [N_CH-1:0][DATA_W-1:0] exp_data;
  logic [N_CH-1:0]             exp_ready;
  logic [N_CH-1:0]             act_valid;
  logic [N_CH-1:0][DATA_W-1:0] act_data;

  modport master (
    output exp_valid, exp_data, act_valid, act_data,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_data, act_valid, act_data,
    output exp_ready
  );

endinterface

// File: rtl/stream_verify_checker_sync_fifo.sv
// rtl/stream_verify_checker_sync_fifo.sv - per-channel expected-word buffer with flush
module sync_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  // A pop on an empty buffer is dropped; a push on a full buffer only lands if a pop frees a slot.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage array, write port only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; flush empties the buffer in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_verify_checker.sv
// rtl/stream_verify_checker.sv - multi-channel frame checker comparing actual beats to buffered expected words
module stream_verify_checker
  import Package_wimax::*;
#(
  parameter  int N_CH       = DEF_N_CH,
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int FRAME_LEN  = DEF_FRAME_LEN,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter  int ERR_TOL    = DEF_ERR_TOL,
  localparam int CNT_W      = cnt_w(FRAME_LEN)
) (
  input  logic                       clk_ref,
  input  logic                       reset_N,
  input  logic                       start,
  stream_verify_checker_if.slave     s,
  output logic [N_CH-1:0]            done,
  output logic [N_CH-1:0]            pass,
  output logic [N_CH-1:0]            fail,
  output logic [N_CH-1:0][CNT_W-1:0] err_cnt,
  output logic                       all_pass
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    chk_state_t        state_q, state_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic              active, full, empty;
    logic              push, pop, beat, mism;
    logic [DATA_W-1:0] head;

    assign active = (state_q == ST_ARMED) || (state_q == ST_CHECK);

    // Ready also covers the full case when an actual beat pops a word in the same cycle.
    assign s.exp_ready[c] = active && (!full || s.act_valid[c]);

    // Start wins: traffic in the start cycle is thrown away.
    assign beat = active && s.act_valid[c] && !start;
    assign push = active && s.exp_valid[c] && s.exp_ready[c] && !start;
    assign pop  = beat && !empty;
    assign mism = beat && (empty || (s.act_data[c] != head));

    sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk_ref),
      .rst_n     (reset_N),
      .flush     (start),
      .push      (push),
      .push_data (s.exp_data[c]),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty)
    );

    // Channel state, mismatch count and beat count registers.
    always_ff @(posedge clk_ref or negedge reset_N) begin
      if (!reset_N) begin
        state_q <= ST_IDLE;
        err_q   <= '0;
        beat_q  <= '0;
      end else begin
        state_q <= state_d;
        err_q   <= err_d;
        beat_q  <= beat_d;
      end
    end

    // Next state: abort on tolerance overflow takes precedence over the frame-complete verdict.
    always_comb begin
      state_d = state_q;
      err_d   = err_q;
      beat_d  = beat_q;
      if (start) begin
        state_d = ST_ARMED;
        err_d   = '0;
        beat_d  = '0;
      end else if (beat) begin
        beat_d = beat_q + 1'b1;
        if (mism && (err_q != CNT_W'(FRAME_LEN))) err_d = err_q + 1'b1;
        if (mism && ((int'(err_q) + 1) > ERR_TOL)) state_d = ST_FAIL;
        else if (beat_q == CNT_W'(FRAME_LEN - 1)) state_d = ST_PASS;
        else state_d = ST_CHECK;
      end
    end

    assign pass[c]    = (state_q == ST_PASS);
    assign fail[c]    = (state_q == ST_FAIL);
    assign done[c]    = pass[c] || fail[c];
    assign err_cnt[c] = err_q;
  end

  assign all_pass = &pass;

endmodule
